adder_seq_ctrl: RTL and testbench
=================================

# adder_seq_ctrl

Multi-cycle add/subtract sequencer that time-shares one external 4-bit carry-lookahead adder slice to compute WIDTH-bit sums nibble by nibble, least-significant nibble first. It sits between the execute-stage issue logic (valid/ready operand handshake) and the shared 4-bit CLA slice. It trades latency for area on the low-cost NovaEdge32 ALU configuration. Its outputs are the WIDTH-bit result, the carry-out and the signed-overflow flag.

## Interface
- WIDTH, 32, operand width; must be a multiple of 4 and at least 8. N = WIDTH/4 nibble steps.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high; forces IDLE.
- in_valid  input  1  operands valid.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A − B, 0 = A + B; sampled with operands.
- out_valid  output  1  result, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- slice_x  output  4  nibble of A driven to the CLA slice.
- slice_y  output  4  nibble of B driven to the slice, inverted when sub = 1.
- slice_cin  output  1  carry into the slice.
- slice_sum  input  4  slice sum; combinational from slice_x, slice_y and slice_cin.
- slice_cout  input  1  slice carry-out.

## Operation
- States are IDLE, RUN and DONE, with a step counter idx of width clog2(N).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register a_r = a, b_r = b ^ {WIDTH{sub}}, cy = sub, and idx = 0, then go to RUN.
- RUN:
  - slice_x = a_r[4*idx+3 : 4*idx], slice_y = b_r[4*idx+3 : 4*idx], slice_cin = cy.
  - At each edge: result[4*idx+3 : 4*idx] <= slice_sum, cy <= slice_cout, idx <= idx + 1.
  - At the edge where idx = N−1: cout <= slice_cout, compute ovf, and go to DONE.
- ovf = (a_r[WIDTH−1] == b_r[WIDTH−1]) & (final result[WIDTH−1] != a_r[WIDTH−1]). Compute it from the captured MSB nibble.
- DONE:
  - out_valid = 1; result, cout and ovf are held stable.
  - On out_valid & out_ready, go to IDLE.
- No back-to-back accept: in_ready is 0 in RUN and DONE, and in_valid is ignored there.
- slice_x, slice_y and slice_cin are 0 outside RUN.
- result, cout and ovf keep their last values in IDLE until the next operation overwrites the nibbles.
- All arithmetic is modulo 2^WIDTH.
- Reset at any time, including mid-RUN or in DONE:
  - The operation is aborted; no partial result is ever presented.
  - State = IDLE, idx = 0, cy = 0, result = 0, cout = 0, ovf = 0.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, cout = 0, ovf = 0, slice_x = 0, slice_y = 0, slice_cin = 0.
- Latency: if operands are accepted at edge E, out_valid rises after edge E+N (N = 8 for WIDTH = 32).
- Minimum issue interval is N+2 cycles: accept, N RUN cycles, then the DONE handshake cycle returns to IDLE.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Slice path: the slice is purely combinational, so one nibble is computed per cycle. The timing budget is the register → slice → register path.
- Backpressure: out_valid stays high with a stable result for any number of cycles that out_ready is low.

## Test plan
- Basic add: a = 0x0000000F, b = 0x00000001, sub = 0 → result 0x00000010, cout 0, ovf 0; out_valid exactly 8 cycles after accept.
- Full carry ripple through all 8 steps: a = 0xFFFFFFFF, b = 0x00000001, sub = 0 → result 0x00000000, cout 1, ovf 0.
- Signed overflow on add: a = 0x7FFFFFFF, b = 0x00000001, sub = 0 → result 0x80000000, cout 0, ovf 1.
- Subtract with borrow: a = 5, b = 7, sub = 1 → result 0xFFFFFFFE, cout 0, ovf 0.
- Subtract with overflow: a = 0x80000000, b = 1, sub = 1 → result 0x7FFFFFFF, cout 1, ovf 1.
- Backpressure and no double-accept:
  - Hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 → result stays stable and in_ready stays 0.
  - The next operation is accepted only after out_ready and the return to IDLE.
- Reset mid-RUN: assert rst while idx = 3 → all outputs are at their reset values immediately, with no out_valid pulse.
  - A fresh operation 0x12345678 + 0x11111111 then produces 0x23456789.

Source files
------------

// File: rtl/adder_seq_ctrl_if.sv
// Operand, result and CLA-slice signals of the nibble-serial add/subtract sequencer.
// slave = the sequencer; master = issue logic, consumer and the external slice.
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic [3:0]       slice_x;
  logic [3:0]       slice_y;
  logic             slice_cin;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  modport slave (
    input  in_valid, a, b, sub, out_ready, slice_sum, slice_cout,
    output in_ready, out_valid, result, cout, ovf, slice_x, slice_y, slice_cin
  );

  modport master (
    output in_valid, a, b, sub, out_ready, slice_sum, slice_cout,
    input  in_ready, out_valid, result, cout, ovf, slice_x, slice_y, slice_cin
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one external 4-bit CLA slice,
// processing one nibble per cycle, least-significant nibble first.
module adder_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  adder_seq_ctrl_if.slave                bus,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(WIDTH/4)-1:0]     dbg_idx
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic [IW-1:0]    idx;
  logic             cy;
  logic             cout_r;
  logic             ovf_r;
  logic [IW+1:0]    nib_lsb;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; ready/valid depend only on registered state, never on the partner's signal.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign dbg_state     = state;
  assign dbg_idx       = idx;
  assign nib_lsb       = {idx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)          state_nx = RUN;
      RUN:     if (idx == LAST_IDX)       state_nx = DONE;
      DONE:    if (bus.out_ready)         state_nx = IDLE;
      default:                            state_nx = IDLE;
    endcase
  end

  // Slice operands are only meaningful while stepping; held at zero otherwise.
  always_comb begin
    bus.slice_x   = 4'h0;
    bus.slice_y   = 4'h0;
    bus.slice_cin = 1'b0;
    if (state == RUN) begin
      bus.slice_x   = a_r[nib_lsb +: 4];
      bus.slice_y   = b_r[nib_lsb +: 4];
      bus.slice_cin = cy;
    end
  end

  // B is stored pre-inverted and the carry seeded with sub, so subtraction
  // is A + ~B + 1 through the same add path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      idx      <= '0;
      cy       <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b ^ {WIDTH{bus.sub}};
            cy  <= bus.sub;
            idx <= '0;
          end
        end
        RUN: begin
          result_r[nib_lsb +: 4] <= bus.slice_sum;
          cy                     <= bus.slice_cout;
          idx                    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_r <= bus.slice_cout;
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                      (bus.slice_sum[3] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and random operations on adder_seq_ctrl with a behavioural CLA slice,
// checked against an arithmetic reference model through an expected queue.
module tb_adder_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 4;
  localparam int W     = WIDTH + 2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [2:0] dbg_idx;

  int tests;
  int fails;

  logic [W-1:0] exp_q[$];
  logic [1:0]   idle_code;

  adder_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_idx   (dbg_idx)
  );

  // External combinational 4-bit adder slice
  assign {bus.slice_cout, bus.slice_sum} =
    5'(bus.slice_x) + 5'(bus.slice_y) + 5'(bus.slice_cin);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic sub);
    logic [WIDTH:0] s;
    longint sa, sb, sr, smax, smin;
    logic ov;
    s    = sub ? ({1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1)) : ({1'b0, a} + {1'b0, b});
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sr   = sub ? (sa - sb) : (sa + sb);
    smax = (64'sd1 <<< (WIDTH - 1)) - 1;
    smin = -(64'sd1 <<< (WIDTH - 1));
    ov   = (sr > smax) || (sr < smin);
    return {ov, s};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called on a negedge while the DUT is idle; returns on a negedge back in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input int hold);
    logic [W-1:0]     exp;
    logic [WIDTH-1:0] bx;
    int k;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    exp_q.push_back(model(a, b, sub));
    bx = sub ? ~b : b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    check("state_left_idle", 64'(dbg_state != idle_code), 64'd1);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      if (k < N) begin
        check("slice_x", 64'(bus.slice_x), 64'(a[4*k +: 4]));
        check("slice_y", 64'(bus.slice_y), 64'(bx[4*k +: 4]));
      end
      check("in_ready_run", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(N));
    exp = exp_q.pop_front();
    // backpressure with a competing operand offered
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_result", 64'(bus.result), 64'(exp[WIDTH-1:0]));
      check("bp_slice_zero", 64'({bus.slice_x, bus.slice_y, bus.slice_cin}), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("out_valid", 64'(bus.out_valid), 64'd1);
    check("result", 64'(bus.result), 64'(exp[WIDTH-1:0]));
    check("cout", 64'(bus.cout), 64'(exp[WIDTH]));
    check("ovf", 64'(bus.ovf), 64'(exp[WIDTH+1]));
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_hold_result", 64'(bus.result), 64'(exp[WIDTH-1:0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_cout_ovf"}, 64'({bus.cout, bus.ovf}), 64'd0);
    check({tag, "_slice"}, 64'({bus.slice_x, bus.slice_y, bus.slice_cin}), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    tests = 0;
    fails = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    idle_code = dbg_state;
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h0000000F, 32'h00000001, 1'b0, 0);
    check("add_basic", 64'({bus.ovf, bus.cout, bus.result}), 64'({2'b00, 32'h00000010}));
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1);
    check("add_ripple", 64'({bus.ovf, bus.cout, bus.result}), 64'({2'b01, 32'h00000000}));
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    check("add_ovf", 64'({bus.ovf, bus.cout, bus.result}), 64'({2'b10, 32'h80000000}));
    run_op(32'd5, 32'd7, 1'b1, 2);
    check("sub_borrow", 64'({bus.ovf, bus.cout, bus.result}), 64'({2'b00, 32'hFFFFFFFE}));
    run_op(32'h80000000, 32'h00000001, 1'b1, 0);
    check("sub_ovf", 64'({bus.ovf, bus.cout, bus.result}), 64'({2'b11, 32'h7FFFFFFF}));
    run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 5);

    // abort mid-RUN at idx 3
    bus.in_valid = 1'b1;
    bus.a        = 32'hAAAA5555;
    bus.b        = 32'h12121212;
    bus.sub      = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idx", 64'(dbg_idx), 64'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    check("abort_no_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      check("abort_stays_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1);
    check("after_abort", 64'(bus.result), 64'(32'h23456789));

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = ra;
      run_op(ra, rb, rs, $urandom_range(0, 3));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
